// File: rtl/usb_gpx_cond_pkg.sv
// Shared constants for the GPX pin conditioner: register map, edge modes and
// counter width, plus the edge qualification helper used by the top.
package usb_gpx_cond_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] REG_LEVEL = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_EDGE  = 2'd2;
  localparam logic [1:0] REG_CNT   = 2'd3;

  // Qualifying edge selection
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Width of the qualifying-edge counter
  localparam int EDGE_CNT_W = 16;

  // True when the transition prev -> cur counts as an edge for this mode.
  // Any mode value other than rise/fall is treated as "both".
  function automatic logic edge_qualify(input int mode, input logic cur, input logic prev);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (mode)
      EDGE_RISE: edge_qualify = rise;
      EDGE_FALL: edge_qualify = fall;
      default:   edge_qualify = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/usb_gpx_cond_sync_filter.sv
// Synchronizer chain plus glitch filter for the raw GPX pin. The filtered
// level only moves after the synchronized pin has disagreed with it for
// FILT_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module gpx_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic [CNT_W-1:0]       filt_cnt;

  // Shift the asynchronous pin through the synchronizer chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; commit the new level on the last one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt <= '0;
      level    <= 1'b0;
    end else if (sync_q == level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == CNT_LAST) begin
      filt_cnt <= '0;
      level    <= sync_q;
    end else begin
      filt_cnt <= filt_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/usb_gpx_cond.sv
// GPX pin conditioner: synchronizes and filters the USB controller's GPX pin
// for the PIO, captures and counts qualifying edges of the filtered level,
// and raises a maskable level interrupt. Four-word Avalon-MM slave.
//
// Bus semantics: the slave never stalls (no waitrequest). A write takes
// effect on the clock edge where write is high. readdata is a registered
// copy of the word at the current address, so it is valid one cycle after
// the address is presented; reads have no side effects.
module usb_gpx_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gpx_pin,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        gpx_level,
  output logic        irq
);

  import usb_gpx_cond_pkg::*;

  localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

  logic                  level_d;
  logic                  edge_hit;
  logic                  edge_cap;
  logic                  irq_mask;
  logic [EDGE_CNT_W-1:0] edge_cnt;
  logic                  wr_mask;
  logic                  wr_edge;
  logic                  wr_cnt;
  logic [31:0]           rd_next;
  logic                  unused_wdata;

  // Only bit 0 of writedata is ever stored
  assign unused_wdata = ^writedata[31:1];

  gpx_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_sync_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (gpx_pin),
    .level   (gpx_level)
  );

  // Decode register writes
  assign wr_mask = write && (address == REG_MASK);
  assign wr_edge = write && (address == REG_EDGE);
  assign wr_cnt  = write && (address == REG_CNT);

  // Delayed copy of the filtered level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= gpx_level;
    end
  end

  // Reset leaves level_d at 0, so a high pin after reset yields a real rising edge
  always_comb begin
    edge_hit = edge_qualify(EDGE_MODE, gpx_level, level_d);
  end

  // Edge capture flag: a new edge beats a simultaneous write-1-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= 1'b0;
    end else if (edge_hit) begin
      edge_cap <= 1'b1;
    end else if (wr_edge && writedata[0]) begin
      edge_cap <= 1'b0;
    end
  end

  // Edge counter: any write clears it, a coincident edge counts as the first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
    end else if (wr_cnt) begin
      edge_cnt <= edge_hit ? CNT_ONE : '0;
    end else if (edge_hit) begin
      edge_cnt <= edge_cnt + CNT_ONE;
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= 1'b0;
    end else if (wr_mask) begin
      irq_mask <= writedata[0];
    end
  end

  // Select the word for the current address; unused bits read 0
  always_comb begin
    rd_next = '0;
    case (address)
      REG_LEVEL: rd_next[0] = gpx_level;
      REG_MASK:  rd_next[0] = irq_mask;
      REG_EDGE:  rd_next[0] = edge_cap;
      default:   rd_next[EDGE_CNT_W-1:0] = edge_cnt;
    endcase
  end

  // Register read data every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = edge_cap & irq_mask;

endmodule
